johnson_pwm_gen: RTL and testbench
==================================

Name: johnson_pwm_gen

Overview:
Parametrised successor to the fixed 8-bit Johnson counter.
- Johnson ring of WIDTH bits (2*WIDTH states) with prescaled advance, run/hold enable and selectable direction.
- Synchronous phase load, a decoded step index and a one-cycle wrap pulse.
- A registered PWM output whose high time is set by a duty count in Johnson steps.
- Drives uo_out-class pins in the top level as a multi-phase and PWM source.

Parameters:
WIDTH, 8, Johnson ring width in bits; >=2; period = 2*WIDTH steps
DIV_W, 8, prescaler width in bits
CNT_W, $clog2(2*WIDTH)+1, width of step/duty/load_step; derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, ACTIVE-HIGH (codebase port name kept; 1 = reset)
en  input  1  1 = prescaler counts / ring may advance; 0 = hold
dir  input  1  0 = forward, 1 = reverse
presc  input  DIV_W  ring advances once per presc+1 enabled cycles
duty  input  CNT_W  number of steps per period with pwm high
load  input  1  synchronous phase load strobe
load_step  input  CNT_W  step index to load
q  output  WIDTH  Johnson ring state, registered
step  output  CNT_W  current step index 0..2*WIDTH-1, registered
wrap  output  1  one-cycle pulse on period boundary, registered
pwm  output  1  PWM output, registered

Behaviour:
- Reset (rst_n=1, asynchronous, no clock needed): q=0, step=0, internal prescaler pc=0, wrap=0, pwm=0. All state holds while reset is asserted.
- Step encoding, W=WIDTH, k=step:
  - k in 0..W: top k bits are 1, rest 0.
  - k in W+1..2W-1: top k-W bits are 0, rest 1.
  - q and step change on the same edge and always agree.
- Advance rule: advance when en=1 and pc>=presc; on that edge pc<=0. If en=1 and pc<presc, pc<=pc+1. If en=0, pc and q hold. presc=0 means advance every enabled cycle. Using >= means lowering presc mid-count fires on the next enabled cycle.
- Forward advance (dir=0): q <= {~q[0], q[W-1:1]}, step <= step+1, wrapping 2W-1 to 0.
- Reverse advance (dir=1): q <= {q[W-2:0], ~q[W-1]}, step <= step-1, wrapping 0 to 2W-1. dir is sampled per advance; a direction change costs no extra cycle.
- wrap: 1 for exactly the cycle in which the new state follows a boundary crossing (forward into step 0, reverse into step 2W-1). 0 otherwise, including on hold and load.
- load=1, synchronous, evaluated regardless of en:
  - Has priority over any advance in the same cycle.
  - q/step <= encoding of load_step; if load_step >= 2W, load step 0.
  - pc <= 0, wrap <= 0.
- pwm: every clock (not in reset), pwm <= (step_next < duty), where step_next is the step value being registered on that edge. pwm therefore aligns with q/step in the same cycle.
  - A duty change takes effect on the next edge.
  - duty=0: pwm always 0. duty>=2W: pwm always 1.
- No illegal ring states are reachable. Only reset or load changes q other than by an advance.

Test Plan:
1. WIDTH=8, reset then en=1, presc=0, dir=0, duty=0:
   - q = 00,80,C0,E0,F0,F8,FC,FE,FF,7F,3F,1F,0F,07,03,01,00 on successive cycles.
   - step = 0..15 then 0.
   - wrap=1 only in the cycle q returns to 00.
2. presc=2, en=1: q advances every 3rd cycle. Drop en for 5 cycles mid-count: q, step and the prescaler phase hold, and counting resumes where it stopped. Change presc 5→0 with pc=3: advance occurs on the next enabled cycle.
3. dir=1 from reset: q = 00,01,03,07 with step = 0,15,14,13; wrap=1 on the first advance. At step 5 (q=F8), set dir=1: next q=F0, step=4.
4. presc=0, duty=5: pwm=1 exactly in the cycles with step 0..4, which is 5 of every 16 cycles. duty=0: pwm stays 0. duty=16 and duty=31: pwm=1 in every cycle after the first post-reset edge.
5. Load cases:
   - en=0, load=1, load_step=11: next cycle q=1F, step=11, wrap=0.
   - load_step=20: q=00, step=0.
   - load asserted on an advance cycle: the loaded value wins and pc=0.
6. Assert rst_n=1 mid-run between clock edges: q, step, wrap and pwm go to 0 immediately. Release rst_n: the first advance occurs per presc, counting from pc=0.

Source files
------------

// File: rtl/johnson_pwm_gen.sv
// rtl/johnson_pwm_gen.sv - Johnson ring phase generator with prescaler, phase load and PWM
//
// Purpose:
//   A WIDTH-bit Johnson ring that walks through 2*WIDTH steps.
//   The ring advances once per presc+1 enabled cycles, in either direction.
//   The block can load a phase synchronously, reports the current step index,
//   pulses wrap for one cycle at the period boundary, and drives a registered
//   PWM output that is high while the step is below duty.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active HIGH (1 = reset)
//   en         in   1 = prescaler counts and the ring may advance, 0 = hold
//   dir        in   0 = forward, 1 = reverse
//   presc      in   [DIV_W]  ring advances once per presc+1 enabled cycles
//   duty       in   [CNT_W]  number of steps per period with pwm high
//   load       in   synchronous phase load strobe, overrides advance
//   load_step  in   [CNT_W]  step to load; out-of-range values load step 0
//   q          out  [WIDTH]  Johnson ring state
//   step       out  [CNT_W]  current step index 0..2*WIDTH-1
//   wrap       out  one-cycle pulse on entering the period boundary step
//   pwm        out  registered PWM output, aligned with q/step

module johnson_pwm_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8,
    parameter int CNT_W = $clog2(2 * WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic [DIV_W-1:0] presc,
    input  logic [CNT_W-1:0] duty,
    input  logic             load,
    input  logic [CNT_W-1:0] load_step,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] step,
    output logic             wrap,
    output logic             pwm
);

    localparam int             PERIOD    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(PERIOD - 1);

    logic [WIDTH-1:0] ring_q, ring_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [DIV_W-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic             pwm_q, pwm_d;
    logic [CNT_W-1:0] ld_step;

    // Ring pattern for step k: k <= WIDTH fills ones from the MSB down;
    // beyond WIDTH, zeros fill in from the MSB while ones remain at the bottom.
    function automatic logic [WIDTH-1:0] encode(input logic [CNT_W-1:0] k);
        logic [WIDTH-1:0] r;
        int               ki;
        ki = int'(k);
        for (int i = 0; i < WIDTH; i++) begin
            if (ki <= WIDTH) begin
                r[i] = (i >= WIDTH - ki);
            end else begin
                r[i] = (i < PERIOD - ki);
            end
        end
        return r;
    endfunction

    assign ld_step = (load_step >= PERIOD_C) ? '0 : load_step;

    always_comb begin
        ring_d = ring_q;
        step_d = step_q;
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (load) begin
            ring_d = encode(ld_step);
            step_d = ld_step;
            pc_d   = '0;
        end else if (en) begin
            // >= so a presc lowered below the running count fires immediately
            if (pc_q >= presc) begin
                pc_d = '0;
                if (!dir) begin
                    ring_d = {~ring_q[0], ring_q[WIDTH-1:1]};
                    step_d = (step_q == LAST_STEP) ? '0 : step_q + CNT_W'(1);
                    wrap_d = (step_q == LAST_STEP);
                end else begin
                    ring_d = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
                    step_d = (step_q == '0) ? LAST_STEP : step_q - CNT_W'(1);
                    wrap_d = (step_q == '0);
                end
            end else begin
                pc_d = pc_q + DIV_W'(1);
            end
        end
        // Compare against the step being registered so pwm lines up with q/step.
        pwm_d = (step_d < duty);
    end

    // rst_n keeps its legacy name but is active high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ring_q <= '0;
            step_q <= '0;
            pc_q   <= '0;
            wrap_q <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            ring_q <= ring_d;
            step_q <= step_d;
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
            pwm_q  <= pwm_d;
        end
    end

    assign q    = ring_q;
    assign step = step_q;
    assign wrap = wrap_q;
    assign pwm  = pwm_q;

endmodule

// File: tb/tb_johnson_pwm_gen.sv
// tb/tb_johnson_pwm_gen.sv - scoreboard testbench for johnson_pwm_gen

module tb_johnson_pwm_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic [7:0] presc;
    logic [4:0] duty;
    logic       load;
    logic [4:0] load_step;
    logic [7:0] q;
    logic [4:0] step;
    logic       wrap;
    logic       pwm;

    always #5 clk = ~clk;

    johnson_pwm_gen #(.WIDTH(8), .DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .dir       (dir),
        .presc     (presc),
        .duty      (duty),
        .load      (load),
        .load_step (load_step),
        .q         (q),
        .step      (step),
        .wrap      (wrap),
        .pwm       (pwm)
    );

    typedef struct {
        logic [7:0] q;
        logic [4:0] step;
        logic       wrap;
        logic       pwm;
        int         tag;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cyc_cnt = 0;

    logic [7:0] qf[16] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                           8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [7:0] xq, input logic [4:0] xs,
                         input logic xw, input logic xp);
        n_vec++;
        if (q !== xq || step !== xs || wrap !== xw || pwm !== xp) begin
            n_bad++;
            $display("FAIL %s: got q=%h step=%0d wrap=%b pwm=%b, expected q=%h step=%0d wrap=%b pwm=%b",
                     name, q, step, wrap, pwm, xq, xs, xw, xp);
        end
    endtask

    // Monitor: an entry is due once the edge after its issue has occurred.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].tag < cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, e.q, e.step, e.wrap, e.pwm);
        end
    end

    // Inputs are already driven; queue the state expected after the next edge.
    task automatic tick(input string name, input logic [7:0] xq, input logic [4:0] xs,
                        input logic xw, input logic xp);
        exp_t e;
        e.q    = xq;
        e.step = xs;
        e.wrap = xw;
        e.pwm  = xp;
        e.tag  = cyc_cnt;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b0; dir = 1'b0; presc = 8'd0; duty = 5'd0; load = 1'b0; load_step = 5'd0;
        @(posedge clk);
        #1;
        check("reset_state", 8'h00, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
    endtask

    task automatic fwd_run(input string name, input logic [4:0] d, input int n);
        int k;
        duty = d; en = 1'b1; presc = 8'd0; dir = 1'b0; load = 1'b0;
        for (int i = 1; i <= n; i++) begin
            k = i % 16;
            tick(name, qf[k], 5'(k), (k == 0), (k < int'(d)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; dir = 1'b0; presc = 8'd0; duty = 5'd0; load = 1'b0; load_step = 5'd0;
        #1 rst_n = 1'b1;
        #1 check("async_reset_no_clk", 8'h00, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;

        // Forward sequence, full period and wrap
        fwd_run("fwd_seq", 5'd0, 17);

        // Prescaler, hold and presc lowering
        do_reset();
        en = 1'b1; presc = 8'd2;
        tick("presc_pc1", 8'h00, 5'd0, 1'b0, 1'b0);
        tick("presc_pc2", 8'h00, 5'd0, 1'b0, 1'b0);
        tick("presc_adv1", 8'h80, 5'd1, 1'b0, 1'b0);
        tick("presc_pc1b", 8'h80, 5'd1, 1'b0, 1'b0);
        tick("presc_pc2b", 8'h80, 5'd1, 1'b0, 1'b0);
        tick("presc_adv2", 8'hC0, 5'd2, 1'b0, 1'b0);
        tick("presc_pc1c", 8'hC0, 5'd2, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick("hold_en0", 8'hC0, 5'd2, 1'b0, 1'b0);
        en = 1'b1;
        tick("resume_pc2", 8'hC0, 5'd2, 1'b0, 1'b0);
        tick("resume_adv", 8'hE0, 5'd3, 1'b0, 1'b0);
        presc = 8'd5;
        tick("p5_pc1", 8'hE0, 5'd3, 1'b0, 1'b0);
        tick("p5_pc2", 8'hE0, 5'd3, 1'b0, 1'b0);
        tick("p5_pc3", 8'hE0, 5'd3, 1'b0, 1'b0);
        presc = 8'd0;
        tick("presc_lowered", 8'hF0, 5'd4, 1'b0, 1'b0);

        // Reverse direction and mid-run direction change
        do_reset();
        en = 1'b1; dir = 1'b1;
        tick("rev_1", 8'h01, 5'd15, 1'b1, 1'b0);
        tick("rev_2", 8'h03, 5'd14, 1'b0, 1'b0);
        tick("rev_3", 8'h07, 5'd13, 1'b0, 1'b0);
        do_reset();
        fwd_run("fwd_to5", 5'd0, 5);
        dir = 1'b1;
        tick("dir_flip_rev", 8'hF0, 5'd4, 1'b0, 1'b0);
        dir = 1'b0;
        tick("dir_flip_fwd", 8'hF8, 5'd5, 1'b0, 1'b0);

        // PWM duty cases
        do_reset();
        fwd_run("pwm_duty5", 5'd5, 32);
        do_reset();
        fwd_run("pwm_duty16", 5'd16, 17);
        do_reset();
        fwd_run("pwm_duty31", 5'd31, 17);

        // Phase load
        do_reset();
        duty = 5'd8; en = 1'b0; load = 1'b1; load_step = 5'd11;
        tick("load_11", 8'h1F, 5'd11, 1'b0, 1'b0);
        load_step = 5'd20;
        tick("load_oor", 8'h00, 5'd0, 1'b0, 1'b1);
        en = 1'b1; presc = 8'd0; load_step = 5'd3;
        tick("load_vs_adv", 8'hE0, 5'd3, 1'b0, 1'b1);
        load = 1'b0; presc = 8'd2;
        tick("ld_pc1", 8'hE0, 5'd3, 1'b0, 1'b1);
        tick("ld_pc2", 8'hE0, 5'd3, 1'b0, 1'b1);
        load = 1'b1; load_step = 5'd6;
        tick("load_on_adv", 8'hFC, 5'd6, 1'b0, 1'b1);
        load = 1'b0;
        tick("ld_pc_clr1", 8'hFC, 5'd6, 1'b0, 1'b1);
        tick("ld_pc_clr2", 8'hFC, 5'd6, 1'b0, 1'b1);
        tick("ld_adv", 8'hFE, 5'd7, 1'b0, 1'b1);
        load = 1'b1; load_step = 5'd15; presc = 8'd0;
        tick("load_15", 8'h01, 5'd15, 1'b0, 1'b0);
        load_step = 5'd0;
        tick("load_0_nowrap", 8'h00, 5'd0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b0;
        tick("hold_nowrap", 8'h00, 5'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-run
        do_reset();
        duty = 5'd8; en = 1'b1; presc = 8'd0;
        tick("pre_rst_1", 8'h80, 5'd1, 1'b0, 1'b1);
        tick("pre_rst_2", 8'hC0, 5'd2, 1'b0, 1'b1);
        tick("pre_rst_3", 8'hE0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("async_rst_mid", 8'h00, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("rst_hold", 8'h00, 5'd0, 1'b0, 1'b0);
        presc = 8'd2;
        rst_n = 1'b0;
        tick("post_rst_pc1", 8'h00, 5'd0, 1'b0, 1'b1);
        tick("post_rst_pc2", 8'h00, 5'd0, 1'b0, 1'b1);
        tick("post_rst_adv", 8'h80, 5'd1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
